// File: rtl/itch_message_encoder.sv
// ITCH 5.0 message encoder: one request in, big-endian byte stream out.
// Frames are built whole at acceptance and shifted out a byte at a time.
module itch_message_encoder #(
  parameter int GAP_CYCLES = 0,
  parameter int CNT_W      = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             msg_valid,
  output logic             msg_ready,
  input  logic [7:0]       msg_type,
  input  logic [15:0]      msg_locate,
  input  logic [15:0]      msg_tracking,
  input  logic [47:0]      msg_timestamp,
  input  logic [63:0]      msg_order_ref,
  input  logic [63:0]      msg_new_order_ref,
  input  logic             msg_side,
  input  logic [31:0]      msg_shares,
  input  logic [31:0]      msg_price,
  input  logic [63:0]      msg_stock_symbol,
  input  logic [63:0]      msg_match_id,
  output logic [7:0]       byte_out,
  output logic             valid_out,
  input  logic             out_ready,
  output logic             msg_start,
  output logic             msg_end,
  output logic             type_error,
  output logic [CNT_W-1:0] msg_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;

  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] GAP_LAST =
    GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  logic [1:0]       state_q, state_d;
  logic [5:0]       idx_q, idx_d;
  logic [5:0]       len_q, len_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic [351:0]     buf_q, buf_d;
  logic             terr_q, terr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [87:0]  hdr;
  logic [7:0]   side_b;
  logic [351:0] pkt;
  logic [5:0]   plen;
  logic         ok;
  logic         send;
  logic         last;

  // Assemble the full left-aligned frame and its length from the request.
  always_comb begin
    hdr    = {msg_type, msg_locate, msg_tracking, msg_timestamp};
    side_b = msg_side ? 8'h53 : 8'h42;
    pkt    = '0;
    plen   = '0;
    ok     = 1'b1;
    case (msg_type)
      8'h41: begin
        pkt  = {hdr, msg_order_ref, side_b, msg_shares,
                msg_stock_symbol, msg_price, 64'd0};
        plen = 6'd36;
      end
      8'h58: begin
        pkt  = {hdr, msg_order_ref, msg_shares, 168'd0};
        plen = 6'd23;
      end
      8'h44: begin
        pkt  = {hdr, msg_order_ref, 200'd0};
        plen = 6'd19;
      end
      8'h55: begin
        pkt  = {hdr, msg_order_ref, msg_new_order_ref,
                msg_shares, msg_price, 72'd0};
        plen = 6'd35;
      end
      8'h45: begin
        pkt  = {hdr, msg_order_ref, msg_shares,
                msg_match_id, 104'd0};
        plen = 6'd31;
      end
      8'h50: begin
        pkt  = {hdr, msg_order_ref, side_b, msg_shares,
                msg_stock_symbol, msg_price, msg_match_id};
        plen = 6'd44;
      end
      default: ok = 1'b0;
    endcase
  end

  assign send = (state_q == S_SEND);
  assign last = (idx_q == len_q - 6'd1);

  // Next-state logic for the IDLE / SEND / GAP sequencer.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    gap_d   = gap_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    terr_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (msg_valid) begin
          if (ok) begin
            buf_d   = pkt;
            len_d   = plen;
            idx_d   = '0;
            state_d = S_SEND;
          end else begin
            terr_d = 1'b1;
          end
        end
      end
      S_SEND: begin
        if (out_ready) begin
          buf_d = {buf_q[343:0], 8'h00};
          idx_d = idx_q + 6'd1;
          if (last) begin
            idx_d   = '0;
            gap_d   = '0;
            cnt_d   = cnt_q + CNT_W'(1);
            state_d = (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
          end
        end
      end
      S_GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GAP_LAST) begin
          gap_d   = '0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      gap_q   <= '0;
      buf_q   <= '0;
      terr_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      gap_q   <= gap_d;
      buf_q   <= buf_d;
      terr_q  <= terr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign msg_ready  = rst && (state_q == S_IDLE);
  assign valid_out  = send;
  assign byte_out   = send ? buf_q[351:344] : 8'h00;
  assign msg_start  = send && (idx_q == 6'd0);
  assign msg_end    = send && last;
  assign type_error = terr_q;
  assign msg_count  = cnt_q;

endmodule

// File: tb/tb_itch_message_encoder.sv
// Self-checking bench for itch_message_encoder.
// Two instances: no gap / 32-bit count, and 2-cycle gap / 2-bit count.
module tb_itch_message_encoder;

  typedef struct packed {
    logic [7:0]  typ;
    logic [15:0] locate;
    logic [15:0] tracking;
    logic [47:0] ts;
    logic [63:0] oref;
    logic [63:0] nref;
    logic        side;
    logic [31:0] shares;
    logic [31:0] price;
    logic [63:0] stock;
    logic [63:0] match;
  } req_t;

  typedef struct {
    logic [7:0] typ;
    int         exp_len;
    bit         exp_err;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst  [2];
  logic       mv   [2];
  logic       ordy [2];
  req_t       rq   [2];
  logic       mr   [2];
  logic       va   [2];
  logic       ms   [2];
  logic       me   [2];
  logic       te   [2];
  logic [7:0] bo   [2];
  logic [31:0] cnt0;
  logic [1:0]  cnt1;

  int ncmp = 0;
  int nfail = 0;
  int cnt_m [2];
  int gapn [2] = '{0, 2};
  int sl;
  logic [7:0] expq [$];

  logic [7:0] add_b [36] = '{
    8'h41, 8'h00, 8'h01, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00,
    8'h12, 8'h34, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77,
    8'h88, 8'h53, 8'h00, 8'h00, 8'h00, 8'h64, 8'h41, 8'h41, 8'h50,
    8'h4C, 8'h20, 8'h20, 8'h20, 8'h20, 8'h00, 8'h01, 8'h86, 8'hA0};

  logic [7:0] vtypes [6] = '{8'h41, 8'h58, 8'h44, 8'h55, 8'h45, 8'h50};

  itch_message_encoder #(.GAP_CYCLES(0), .CNT_W(32)) u0 (
    .clk(clk), .rst(rst[0]),
    .msg_valid(mv[0]), .msg_ready(mr[0]),
    .msg_type(rq[0].typ), .msg_locate(rq[0].locate),
    .msg_tracking(rq[0].tracking), .msg_timestamp(rq[0].ts),
    .msg_order_ref(rq[0].oref), .msg_new_order_ref(rq[0].nref),
    .msg_side(rq[0].side), .msg_shares(rq[0].shares),
    .msg_price(rq[0].price), .msg_stock_symbol(rq[0].stock),
    .msg_match_id(rq[0].match),
    .byte_out(bo[0]), .valid_out(va[0]), .out_ready(ordy[0]),
    .msg_start(ms[0]), .msg_end(me[0]), .type_error(te[0]),
    .msg_count(cnt0)
  );

  itch_message_encoder #(.GAP_CYCLES(2), .CNT_W(2)) u1 (
    .clk(clk), .rst(rst[1]),
    .msg_valid(mv[1]), .msg_ready(mr[1]),
    .msg_type(rq[1].typ), .msg_locate(rq[1].locate),
    .msg_tracking(rq[1].tracking), .msg_timestamp(rq[1].ts),
    .msg_order_ref(rq[1].oref), .msg_new_order_ref(rq[1].nref),
    .msg_side(rq[1].side), .msg_shares(rq[1].shares),
    .msg_price(rq[1].price), .msg_stock_symbol(rq[1].stock),
    .msg_match_id(rq[1].match),
    .byte_out(bo[1]), .valid_out(va[1]), .out_ready(ordy[1]),
    .msg_start(ms[1]), .msg_end(me[1]), .type_error(te[1]),
    .msg_count(cnt1)
  );

  task automatic chk(input int d, input string nm,
                     input logic [63:0] act, input logic [63:0] exp);
    ncmp++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s dut%0d: got %0h expected %0h", nm, d, act, exp);
    end
  endtask

  function automatic logic [31:0] cnt_f(input int d);
    return (d == 0) ? cnt0 : 32'(cnt1);
  endfunction

  function automatic logic [31:0] cnt_e(input int d);
    return (d == 0) ? 32'(cnt_m[0]) : 32'(cnt_m[1] % 4);
  endfunction

  function automatic bit is_valid(input logic [7:0] t);
    foreach (vtypes[k]) if (vtypes[k] == t) return 1'b1;
    return 1'b0;
  endfunction

  function automatic req_t rand_req();
    req_t r;
    r.typ      = 8'($urandom);
    r.locate   = 16'($urandom);
    r.tracking = 16'($urandom);
    r.ts       = 48'({$urandom, $urandom});
    r.oref     = {$urandom, $urandom};
    r.nref     = {$urandom, $urandom};
    r.side     = 1'($urandom);
    r.shares   = $urandom;
    r.price    = $urandom;
    r.stock    = {$urandom, $urandom};
    r.match    = {$urandom, $urandom};
    return r;
  endfunction

  // Append the n low bytes of v, most significant first.
  function automatic void pb(input logic [63:0] v, input int n);
    for (int k = n - 1; k >= 0; k--) expq.push_back(v[8*k +: 8]);
  endfunction

  // Reference framing straight from the ITCH field tables.
  function automatic void build(input req_t r);
    logic [7:0] sb;
    sb = r.side ? 8'h53 : 8'h42;
    expq.delete();
    pb(64'(r.typ), 1);
    pb(64'(r.locate), 2);
    pb(64'(r.tracking), 2);
    pb(64'(r.ts), 6);
    pb(r.oref, 8);
    case (r.typ)
      8'h41: begin
        pb(64'(sb), 1); pb(64'(r.shares), 4);
        pb(r.stock, 8); pb(64'(r.price), 4);
      end
      8'h58: pb(64'(r.shares), 4);
      8'h55: begin
        pb(r.nref, 8); pb(64'(r.shares), 4); pb(64'(r.price), 4);
      end
      8'h45: begin
        pb(64'(r.shares), 4); pb(r.match, 8);
      end
      8'h50: begin
        pb(64'(sb), 1); pb(64'(r.shares), 4);
        pb(r.stock, 8); pb(64'(r.price), 4); pb(r.match, 8);
      end
      default: ;
    endcase
  endfunction

  // Enter and leave at a negedge with the encoder idle.
  task automatic send(input int d, input req_t r, input int mode,
                      input bit given, input int abort_at,
                      output int seen);
    int i, cyc, n;
    if (!given) build(r);
    n = expq.size();
    seen = -1;
    chk(d, "ready_idle", 64'(mr[d]), 64'd1);
    mv[d] = 1'b1;
    rq[d] = r;
    @(negedge clk);
    mv[d] = 1'b0;
    rq[d] = rand_req();
    i = 0;
    cyc = 0;
    while (i < n) begin
      if (i == abort_at) return;
      chk(d, "valid", 64'(va[d]), 64'd1);
      chk(d, "byte", 64'(bo[d]), 64'(expq[i]));
      chk(d, "start", 64'(ms[d]), 64'(i == 0));
      chk(d, "end", 64'(me[d]), 64'(i == n - 1));
      chk(d, "ready_busy", 64'(mr[d]), 64'd0);
      case (mode)
        0: ordy[d] = 1'b1;
        1: ordy[d] = (cyc % 2) == 0;
        default: ordy[d] = ($urandom % 3) != 0;
      endcase
      if (ordy[d]) begin
        if (me[d]) seen = i + 1;
        i++;
      end
      cyc++;
      if (cyc > 20 * n + 50) begin
        chk(d, "send_timeout", 64'(i), 64'(n));
        return;
      end
      @(negedge clk);
    end
    for (int g = 0; g < gapn[d]; g++) begin
      chk(d, "gap_valid", 64'(va[d]), 64'd0);
      chk(d, "gap_ready", 64'(mr[d]), 64'd0);
      @(negedge clk);
    end
    chk(d, "post_valid", 64'(va[d]), 64'd0);
    chk(d, "post_ready", 64'(mr[d]), 64'd1);
    cnt_m[d]++;
    chk(d, "count", 64'(cnt_f(d)), 64'(cnt_e(d)));
  endtask

  task automatic bad(input int d, input req_t r);
    chk(d, "ready_idle", 64'(mr[d]), 64'd1);
    mv[d] = 1'b1;
    rq[d] = r;
    @(negedge clk);
    mv[d] = 1'b0;
    chk(d, "terr_pulse", 64'(te[d]), 64'd1);
    chk(d, "terr_valid", 64'(va[d]), 64'd0);
    @(negedge clk);
    chk(d, "terr_clear", 64'(te[d]), 64'd0);
    chk(d, "terr_valid2", 64'(va[d]), 64'd0);
    chk(d, "terr_ready", 64'(mr[d]), 64'd1);
    chk(d, "terr_count", 64'(cnt_f(d)), 64'(cnt_e(d)));
  endtask

  initial begin
    vec_t tbl [9];
    req_t r;
    logic [7:0] t;

    tbl[0] = '{8'h41, 36, 1'b0};
    tbl[1] = '{8'h58, 23, 1'b0};
    tbl[2] = '{8'h44, 19, 1'b0};
    tbl[3] = '{8'h55, 35, 1'b0};
    tbl[4] = '{8'h45, 31, 1'b0};
    tbl[5] = '{8'h50, 44, 1'b0};
    tbl[6] = '{8'h5A, 0, 1'b1};
    tbl[7] = '{8'h61, 0, 1'b1};
    tbl[8] = '{8'h00, 0, 1'b1};

    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b0;
      mv[d] = 1'b0;
      ordy[d] = 1'b1;
      rq[d] = '0;
      cnt_m[d] = 0;
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk(d, "rst_valid", 64'(va[d]), 64'd0);
      chk(d, "rst_byte", 64'(bo[d]), 64'd0);
      chk(d, "rst_start", 64'(ms[d]), 64'd0);
      chk(d, "rst_end", 64'(me[d]), 64'd0);
      chk(d, "rst_terr", 64'(te[d]), 64'd0);
      chk(d, "rst_ready", 64'(mr[d]), 64'd0);
      chk(d, "rst_count", 64'(cnt_f(d)), 64'd0);
      rst[d] = 1'b1;
    end
    @(negedge clk);

    // Add order against the literal byte sequence.
    r = rand_req();
    r.typ = 8'h41; r.locate = 16'h0001; r.tracking = 16'h0002;
    r.ts = 48'h000000001234; r.oref = 64'h1122334455667788;
    r.side = 1'b1; r.shares = 32'd100;
    r.stock = 64'h4141504C20202020; r.price = 32'h000186A0;
    expq.delete();
    foreach (add_b[k]) expq.push_back(add_b[k]);
    send(0, r, 0, 1'b1, -1, sl);
    chk(0, "add_len", 64'(sl), 64'd36);

    // Delete with alternating backpressure.
    r = rand_req();
    r.typ = 8'h44; r.oref = 64'hDEADBEEF00000001;
    send(0, r, 1, 1'b0, -1, sl);
    chk(0, "del_len", 64'(sl), 64'd19);

    // Unsupported type, then a normal cancel.
    r = rand_req();
    r.typ = 8'h5A;
    bad(0, r);
    r = rand_req();
    r.typ = 8'h58;
    send(0, r, 0, 1'b0, -1, sl);
    chk(0, "x_len", 64'(sl), 64'd23);

    // Every type with random fields and random backpressure.
    for (int k = 0; k < 9; k++) begin
      r = rand_req();
      r.typ = tbl[k].typ;
      if (tbl[k].exp_err) begin
        bad(0, r);
      end else begin
        send(0, r, 2, 1'b0, -1, sl);
        chk(0, "tbl_len", 64'(sl), 64'(tbl[k].exp_len));
      end
    end

    // Reset in the middle of a replace, then a full replace.
    r = rand_req();
    r.typ = 8'h55;
    send(0, r, 0, 1'b0, 10, sl);
    chk(0, "pre_rst_byte", 64'(bo[0]), 64'(expq[10]));
    rst[0] = 1'b0;
    @(negedge clk);
    chk(0, "mid_rst_valid", 64'(va[0]), 64'd0);
    chk(0, "mid_rst_count", 64'(cnt0), 64'd0);
    chk(0, "mid_rst_ready", 64'(mr[0]), 64'd0);
    rst[0] = 1'b1;
    cnt_m[0] = 0;
    @(negedge clk);
    r = rand_req();
    r.typ = 8'h55;
    send(0, r, 0, 1'b0, -1, sl);
    chk(0, "u_len", 64'(sl), 64'd35);

    // Gap instance: executed then trade back to back.
    r = rand_req();
    r.typ = 8'h45;
    send(1, r, 0, 1'b0, -1, sl);
    chk(1, "e_len", 64'(sl), 64'd31);
    r = rand_req();
    r.typ = 8'h50;
    send(1, r, 0, 1'b0, -1, sl);
    chk(1, "p_len", 64'(sl), 64'd44);

    // Two more to wrap the 2-bit counter to zero.
    for (int k = 0; k < 2; k++) begin
      r = rand_req();
      r.typ = vtypes[$urandom % 6];
      send(1, r, 2, 1'b0, -1, sl);
    end
    chk(1, "wrap_count", 64'(cnt1), 64'd0);

    // Random mix including unsupported types.
    for (int k = 0; k < 12; k++) begin
      r = rand_req();
      if (($urandom % 5) == 0) begin
        t = 8'($urandom);
        while (is_valid(t)) t = t + 8'd1;
        r.typ = t;
        bad(1, r);
      end else begin
        r.typ = vtypes[$urandom % 6];
        send(1, r, 2, 1'b0, -1, sl);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
